field_pack_collector: RTL and testbench

//  Generalised packed-struct assembler. Accepts N_FIELDS fields of FIELD_W bits,

---
 rtl/field_pack_collector_if.sv | 30 +++
 rtl/field_pack_collector.sv | 147 ++++++++++++++
 tb/tb_field_pack_collector.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/field_pack_collector_if.sv
// Field-write and packed-word ports of the field pack collector.
interface field_pack_collector_if #(
    parameter int unsigned N_FIELDS = 4,
    parameter int unsigned FIELD_W  = 1,
    parameter int unsigned IDX_W    = $clog2(N_FIELDS)
);
    logic                          wr_valid;
    logic                          wr_ready;
    logic [IDX_W-1:0]              wr_idx;
    logic [FIELD_W-1:0]            wr_data;
    logic                          flush;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_FIELDS*FIELD_W-1:0]   out_data;
    logic [N_FIELDS-1:0]           out_mask;
    logic                          dup_err;
    logic                          idx_err;

    // Producer/consumer side.
    modport master (
        output wr_valid, wr_idx, wr_data, flush, out_ready,
        input  wr_ready, out_valid, out_data, out_mask, dup_err, idx_err
    );

    // Collector side.
    modport slave (
        input  wr_valid, wr_idx, wr_data, flush, out_ready,
        output wr_ready, out_valid, out_data, out_mask, dup_err, idx_err
    );
endinterface

// File: rtl/field_pack_collector.sv
// Collects fields written one at a time in any order and emits them as one
// packed word. A collect buffer plus an output register give double
// buffering: a finished word waits in the collect buffer (STALL) while the
// output register is still occupied.
module field_pack_collector #(
    parameter int unsigned N_FIELDS  = 4,
    parameter int unsigned FIELD_W   = 1,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned IDX_W     = $clog2(N_FIELDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    field_pack_collector_if.slave bus
);
    localparam int unsigned WORD_W = N_FIELDS * FIELD_W;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   buf_q, buf_d;      // collect buffer, field-index order
    logic [N_FIELDS-1:0] mask_q, mask_d;
    logic                wr_ready_q, wr_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [N_FIELDS-1:0] out_mask_q, out_mask_d;
    logic                dup_q, dup_d;
    logic                idx_q, idx_d;

    logic                wr_acc;
    logic                idx_ok;
    logic                out_pop;
    logic                out_free;
    logic                complete;
    logic [WORD_W-1:0]   buf_w;
    logic [N_FIELDS-1:0] mask_w;

    // Reorders an index-ordered buffer into the output field layout.
    function automatic logic [WORD_W-1:0] pack(input logic [WORD_W-1:0] f);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (MSB_FIRST)
                w[(N_FIELDS-1-i)*FIELD_W +: FIELD_W] = f[i*FIELD_W +: FIELD_W];
            else
                w[i*FIELD_W +: FIELD_W] = f[i*FIELD_W +: FIELD_W];
        end
        return w;
    endfunction

    // Next-state, buffer and output-register logic.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mask_d  = out_mask_q;
        dup_d       = 1'b0;
        idx_d       = 1'b0;
        buf_w       = buf_q;
        mask_w      = mask_q;

        wr_acc   = bus.wr_valid & wr_ready_q;
        idx_ok   = ({1'b0, bus.wr_idx} < (IDX_W+1)'(N_FIELDS));
        out_pop  = out_valid_q & bus.out_ready;
        out_free = ~out_valid_q | bus.out_ready;

        // This cycle's write is folded in before completion is judged.
        for (int i = 0; i < N_FIELDS; i++) begin
            if (wr_acc && idx_ok && (bus.wr_idx == IDX_W'(i))) begin
                buf_w[i*FIELD_W +: FIELD_W] = bus.wr_data;
                mask_w[i]                   = 1'b1;
                dup_d                       = mask_q[i];
            end
        end
        idx_d = wr_acc & ~idx_ok;

        complete = (state_q != STALL) & ((&mask_w) | (bus.flush & (|mask_w)));

        if (out_pop)
            out_valid_d = 1'b0;

        if (state_q == STALL) begin
            if (out_pop) begin
                out_valid_d = 1'b1;
                out_data_d  = pack(buf_q);
                out_mask_d  = mask_q;
                buf_d       = '0;
                mask_d      = '0;
                state_d     = EMPTY;
            end
        end else if (complete && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = pack(buf_w);
            out_mask_d  = mask_w;
            buf_d       = '0;
            mask_d      = '0;
            state_d     = EMPTY;
        end else if (complete) begin
            buf_d   = buf_w;
            mask_d  = mask_w;
            state_d = STALL;
        end else begin
            buf_d   = buf_w;
            mask_d  = mask_w;
            state_d = (|mask_w) ? FILLING : EMPTY;
        end

        wr_ready_d = (state_d != STALL);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            buf_q       <= '0;
            mask_q      <= '0;
            wr_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
            dup_q       <= 1'b0;
            idx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            mask_q      <= mask_d;
            wr_ready_q  <= wr_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mask_q  <= out_mask_d;
            dup_q       <= dup_d;
            idx_q       <= idx_d;
        end
    end

    assign bus.wr_ready  = wr_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.dup_err   = dup_q;
    assign bus.idx_err   = idx_q;
endmodule

// File: tb/tb_field_pack_collector.sv
// Bench: two collectors (LSB-first and MSB-first) share one stimulus stream;
// a field-array reference model predicts words into a scoreboard queue.
module tb_field_pack_collector;
    localparam int unsigned N  = 5;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned DW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [W-1:0]  wr_data = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    field_pack_collector_if #(.N_FIELDS(N), .FIELD_W(W)) ia ();
    field_pack_collector_if #(.N_FIELDS(N), .FIELD_W(W)) ib ();

    assign ia.wr_valid = wr_valid;  assign ib.wr_valid = wr_valid;
    assign ia.wr_idx = wr_idx;      assign ib.wr_idx = wr_idx;
    assign ia.wr_data = wr_data;    assign ib.wr_data = wr_data;
    assign ia.flush = flush;        assign ib.flush = flush;
    assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

    field_pack_collector #(.N_FIELDS(N), .FIELD_W(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bus(ia));
    field_pack_collector #(.N_FIELDS(N), .FIELD_W(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .bus(ib));

    typedef struct {
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic [N-1:0]  mask;
    } exp_t;

    exp_t         q[$];
    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] fld [N];
    logic [N-1:0] written = '0;
    bit           exp_rdy = 1'b1;
    bit           exp_dup = 1'b0;
    bit           exp_idx = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference word: field i is written value or zero, placed per layout rule.
    task automatic emit();
        exp_t e;
        e.da = '0;
        e.db = '0;
        for (int i = 0; i < N; i++) begin
            logic [W-1:0] v;
            v = written[i] ? fld[i] : '0;
            e.da[i*W +: W]       = v;
            e.db[(N-1-i)*W +: W] = v;
        end
        e.mask = written;
        q.push_back(e);
        written = '0;
    endtask

    // Monitor then model update, once per cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            written = '0;
            exp_rdy = 1'b1;
            exp_dup = 1'b0;
            exp_idx = 1'b0;
        end else begin
            chk("wr_ready_lsb", ia.wr_ready, exp_rdy);
            chk("wr_ready_msb", ib.wr_ready, exp_rdy);
            chk("dup_err_lsb", ia.dup_err, exp_dup);
            chk("dup_err_msb", ib.dup_err, exp_dup);
            chk("idx_err_lsb", ia.idx_err, exp_idx);
            chk("idx_err_msb", ib.idx_err, exp_idx);
            chk("out_valid_lsb", ia.out_valid, q.size() != 0);
            chk("out_valid_msb", ib.out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("out_data_lsb", ia.out_data, q[0].da);
                chk("out_data_msb", ib.out_data, q[0].db);
                chk("out_mask_lsb", ia.out_mask, q[0].mask);
                chk("out_mask_msb", ib.out_mask, q[0].mask);
                if (out_ready) void'(q.pop_front());
            end
            exp_dup = 1'b0;
            exp_idx = 1'b0;
            if (exp_rdy) begin
                if (wr_valid) begin
                    if (int'(wr_idx) >= int'(N)) begin
                        exp_idx = 1'b1;
                    end else begin
                        exp_dup = written[int'(wr_idx)];
                        fld[int'(wr_idx)] = wr_data;
                        written[int'(wr_idx)] = 1'b1;
                    end
                end
                if ((&written) || (flush && (|written))) emit();
            end
            // One word in the output register plus one held means stalled.
            exp_rdy = (q.size() < 2);
        end
    end

    task automatic step(input bit v, input int idx, input logic [W-1:0] d, input bit f);
        wr_valid = v;
        wr_idx   = IW'(idx);
        wr_data  = d;
        flush    = f;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int rdy_bias;
    int ridx;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ready", ia.wr_ready, 0);
        chk("rst_out_valid", ia.out_valid, 0);
        chk("rst_out_data", ia.out_data, 0);
        chk("rst_out_mask", ib.out_mask, 0);
        chk("rst_dup_err", ia.dup_err, 0);
        chk("rst_idx_err", ib.idx_err, 0);
        release_rst();
        chk("wr_ready_after_rst", ia.wr_ready, 1);

        // Out-of-order writes, completed by flush on the last write.
        out_ready = 1'b1;
        step(1, 3, 8'hD4, 0);
        step(1, 1, 8'hB2, 0);
        step(1, 0, 8'hA1, 0);
        step(1, 2, 8'hC3, 1);
        chk("dir_latency", ia.out_valid, 1);
        chk("dir_lsb_word", ia.out_data, 40'h00D4C3B2A1);
        chk("dir_msb_word", ib.out_data, 40'hA1B2C3D400);
        chk("dir_mask", ia.out_mask, 5'b01111);

        step(0, 0, 8'h00, 1);
        chk("empty_flush", ia.out_valid, 0);

        for (int i = 0; i < int'(N); i++) step(1, i, 8'h00, 0);
        chk("zero_word", ia.out_data, 40'h0);
        chk("zero_mask", ia.out_mask, 5'b11111);
        step(1, 0, 8'h01, 0);
        for (int i = 1; i < int'(N); i++) step(1, i, 8'h00, 0);
        chk("one_word_lsb", ia.out_data, 40'h0000000001);
        chk("one_word_msb", ib.out_data, 40'h0100000000);

        // Duplicate write: second value wins.
        step(1, 2, 8'h11, 0);
        step(1, 2, 8'h22, 0);
        chk("dup_pulse", ia.dup_err, 1);
        step(0, 0, 8'h00, 1);
        chk("dup_pulse_end", ia.dup_err, 0);
        chk("dup_word", ia.out_data, 40'h0000220000);
        chk("dup_mask", ib.out_mask, 5'b00100);

        // Out-of-range index leaves the mask empty.
        step(1, 7, 8'h99, 0);
        chk("idx_pulse", ia.idx_err, 1);
        step(0, 0, 8'h00, 1);
        chk("idx_no_word", ia.out_valid, 0);

        // Two words against a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < int'(N); i++) step(1, i, W'(8'h10 + i), 0);
        for (int i = 0; i < int'(N); i++) step(1, i, W'(8'h20 + i), 0);
        chk("stall_wr_ready", ia.wr_ready, 0);
        step(1, 0, 8'h77, 1);
        chk("stall_hold_word", ia.out_data, 40'h1413121110);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_second_word", ia.out_data, 40'h2423222120);
        chk("stall_wr_ready_back", ia.wr_ready, 1);
        step(0, 0, 8'h00, 0);

        // Reset with a word in output and a word held.
        out_ready = 1'b0;
        for (int i = 0; i < 2 * int'(N); i++) step(1, i % int'(N), W'(i), 0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", ia.out_valid, 0);
        chk("midrst_wr_ready", ib.wr_ready, 0);
        release_rst();
        chk("midrst_after", ia.out_valid, 0);

        // Reset with a partial word: old fields must not reappear.
        for (int i = 0; i < 3; i++) step(1, i, 8'hEE, 0);
        rst = 1'b1;
        release_rst();
        out_ready = 1'b1;
        step(1, 3, 8'h33, 0);
        step(1, 4, 8'h44, 1);
        chk("partial_rst_word", ia.out_data, 40'h4433000000);
        chk("partial_rst_mask", ia.out_mask, 5'b11000);
        step(0, 0, 8'h00, 0);
        chk("partial_rst_single", ia.out_valid, 0);

        // Randomized traffic with varying back-pressure and one mid-run reset.
        rdy_bias = 3;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) rdy_bias = $urandom_range(0, 3);
            out_ready = ($urandom_range(0, 3) <= rdy_bias);
            ridx = ($urandom_range(0, 9) == 0) ? 5 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(0, 4));
            if (c == 1500) begin
                rst = 1'b1;
                release_rst();
            end
            step($urandom_range(0, 3) != 0, ridx, W'($urandom), $urandom_range(0, 9) == 0);
        end

        out_ready = 1'b1;
        repeat (5) step(0, 0, 8'h00, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
